inst_fetch_unit: RTL and testbench
==================================

Name: inst_fetch_unit

Overview:
- Fetch-side front end between the IF stage, the direct-mapped instruction cache and the byte-wide memory controller.
- On each fetch request it looks up the cache combinationally and returns a cached instruction after one registered cycle.
- On a miss it reads the four instruction bytes from memory one at a time, assembles them little-endian, fills the cache, and hands the word to IF.
- Supports redirect flush from branch resolution and global rdy stall.

Parameters:
ADDR_WIDTH, 32, width of PC and memory byte address
INST_WIDTH, 32, instruction word width
INST_BYTES, 4, bytes fetched per miss (INST_WIDTH/8)

Ports:
clk  in  1  clock
rst  in  1  reset
rdy  in  1  global ready; low freezes all state
fetch_req_i  in  1  IF requests instruction at pc_i
pc_i  in  ADDR_WIDTH  fetch address, word aligned
flush_i  in  1  redirect; abort current fetch
icache_rpc_o  out  ADDR_WIDTH  cache read address (= pc_i, combinational)
icache_hit_i  in  1  cache hit for icache_rpc_o
icache_inst_i  in  INST_WIDTH  cached word
icache_we_o  out  1  cache fill strobe
icache_wpc_o  out  ADDR_WIDTH  fill address
icache_winst_o  out  INST_WIDTH  fill data
mem_req_o  out  1  byte read request to memory controller
mem_addr_o  out  ADDR_WIDTH  byte address requested
mem_ack_i  in  1  byte returned this cycle
mem_data_i  in  8  returned byte
inst_valid_o  out  1  one-cycle pulse: inst_o/inst_pc_o valid
inst_o  out  INST_WIDTH  fetched instruction
inst_pc_o  out  ADDR_WIDTH  PC of inst_o
busy_o  out  1  not in IDLE; IF must hold pc_i / fetch_req_i

Behaviour:
- Reset: rst is synchronous and active-high on clk.
  - State goes to IDLE.
  - All outputs are 0: inst_valid_o, icache_we_o, mem_req_o, busy_o, inst_o, inst_pc_o, icache_winst_o, icache_wpc_o and mem_addr_o.
  - Byte buffer and fetch_pc are cleared.
  - Reset during a fill aborts it with no cache write and no inst_valid_o.
- rdy=0: state, buffers and registered outputs hold. mem_req_o is forced to 0 and mem_ack_i is ignored.
- States: IDLE, B0, B1, B2, B3, FILL.
- IDLE:
  - If fetch_req_i, not flush_i, and icache_hit_i: next cycle inst_valid_o=1, inst_o=icache_inst_i, inst_pc_o=pc_i. State stays IDLE, so a hit takes 1 cycle and back-to-back hits sustain one per cycle.
  - If fetch_req_i, not flush_i, and miss: latch fetch_pc=pc_i and go to B0.
- Bk (k=0..3):
  - mem_req_o=1, mem_addr_o=fetch_pc+k, registered (valid the cycle the state is entered).
  - Address add wraps modulo 2^ADDR_WIDTH.
  - Hold request until mem_ack_i. On ack, buf[8k+7:8k]=mem_data_i and go to B(k+1); from B3, go to FILL.
  - mem_req_o stays asserted across consecutive byte states; memory controller latency is arbitrary (1..N cycles per byte).
- FILL (one cycle):
  - icache_we_o=1, icache_wpc_o=fetch_pc, icache_winst_o=buf.
  - inst_valid_o=1, inst_o=buf, inst_pc_o=fetch_pc.
  - Return to IDLE. Miss latency = 4 byte transactions + 2 cycles.
- busy_o=1 in B0..B3 and FILL.
- flush_i:
  - In IDLE: suppresses the lookup result (no inst_valid_o next cycle).
  - In B0..B3: return to IDLE next cycle, drop mem_req_o, ignore any mem_ack_i in the same cycle; partial buffer discarded, no cache write.
  - Coincident with the B3 ack: go to IDLE with no cache write and no inst_valid_o.
  - In FILL: cache write still occurs (data correct for fetch_pc), inst_valid_o suppressed.
- fetch_req_i while busy_o=1 is ignored. Upstream must hold the request until inst_valid_o.
- All inst_* and icache_w* outputs are registered. icache_rpc_o is combinational pass-through of pc_i.

Decomposition:
- Shared defines header holds:
  - FSM state encodings (3-bit).
  - AddrBus/InstBus/ByteBus widths.
  - True_v/False_v and RstEnable constants already used by cache and pipeline.
- One natural sub-module: fetch_byte_assembler. It holds the 4-byte shift/index buffer with load, clear and word-out. The FSM stays in the top.

Test Plan:
- Hit: cache preloaded at 0x1000 with 0x00A00093; fetch_req_i pc=0x1000 -> next cycle inst_valid_o=1, inst_o=0x00A00093, no mem_req_o.
- Miss fill: pc=0x2004, memory bytes 0x13,0x05,0x10,0x00 with ack latency 3 -> mem_addr_o 0x2004..0x2007 in order; FILL cycle icache_we_o=1, icache_winst_o=inst_o=0x00100513, inst_pc_o=0x2004. A re-fetch of 0x2004 then hits.
- Flush mid-fill: flush_i during B2 -> mem_req_o=0 next cycle, IDLE, no icache_we_o, no inst_valid_o. The next request to the same PC misses again.
- Flush edges: flush_i with B3 ack -> no write, no valid. flush_i in FILL -> icache_we_o=1, inst_valid_o=0.
- rdy stall: rdy=0 for 5 cycles during B1 with mem_ack_i pulsing -> no state change, mem_req_o=0. On resume, fill completes with the correct word.
- Reset mid-fill: rst in B3 -> all outputs 0 next cycle, no cache write. Address wrap: pc=0xFFFFFFFC fetches 0xFFFFFFFC..0xFFFFFFFF.

Source files
------------

// File: rtl/inst_fetch_unit_pkg.sv
// inst_fetch_unit_pkg
// Shared definitions for the fetch front end: bus widths, the fetch FSM
// state encoding, the boolean/reset constants used by the cache and the
// pipeline, and a helper mapping a byte state to its byte lane.
package inst_fetch_unit_pkg;

    // Bus widths shared with the cache and the memory controller
    localparam int AddrBus = 32;
    localparam int InstBus = 32;
    localparam int ByteBus = 8;

    // Number of bytes gathered per miss and the width of a byte index
    localparam int InstBytes    = InstBus / ByteBus;
    localparam int ByteIdxWidth = $clog2(InstBytes);

    // Common boolean and reset-level constants
    localparam logic True_v    = 1'b1;
    localparam logic False_v   = 1'b0;
    localparam logic RstEnable = 1'b1;

    // Fetch FSM states: IDLE waits for a request, B0..B3 collect one byte
    // each from memory, FILL writes the cache and returns the word.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        B0   = 3'd1,
        B1   = 3'd2,
        B2   = 3'd3,
        B3   = 3'd4,
        FILL = 3'd5
    } fetch_state_e;

    // Byte lane written while in a given byte state (0 outside B0..B3)
    function automatic logic [ByteIdxWidth-1:0] byteIndex(input fetch_state_e s);
        logic [ByteIdxWidth-1:0] idx;
        case (s)
            B1:      idx = ByteIdxWidth'(1);
            B2:      idx = ByteIdxWidth'(2);
            B3:      idx = ByteIdxWidth'(3);
            default: idx = '0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/inst_fetch_unit_byte_assembler.sv
// fetch_byte_assembler
// Collects the bytes of one instruction into a little-endian word buffer.
// Byte k of the instruction lands in bits [8k+7:8k].
//
// Ports:
//   clk      clock
//   rst      synchronous active-high reset, clears the buffer
//   clear_i  discard the partially assembled word
//   load_i   write byte_i into lane idx_i
//   idx_i    byte lane to write
//   byte_i   incoming byte from memory
//   word_o   current buffer contents
module fetch_byte_assembler
    import inst_fetch_unit_pkg::*;
#(
    parameter int NUM_BYTES = InstBytes
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear_i,
    input  logic                         load_i,
    input  logic [$clog2(NUM_BYTES)-1:0] idx_i,
    input  logic [ByteBus-1:0]           byte_i,
    output logic [NUM_BYTES*ByteBus-1:0] word_o
);

    logic [NUM_BYTES*ByteBus-1:0] byteBuf_q;
    logic [NUM_BYTES*ByteBus-1:0] byteBuf_d;

    // Buffer register; clear wins over load so a flush never leaves a
    // stale byte behind.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            byteBuf_q <= '0;
        end else begin
            byteBuf_q <= byteBuf_d;
        end
    end

    // Next buffer value: clear, insert one byte into its lane, or hold
    always_comb begin
        byteBuf_d = byteBuf_q;
        if (clear_i) begin
            byteBuf_d = '0;
        end else if (load_i) begin
            byteBuf_d[idx_i*ByteBus +: ByteBus] = byte_i;
        end
    end

    assign word_o = byteBuf_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit
// Fetch front end between IF, the direct-mapped instruction cache and the
// byte-wide memory controller. A hit returns the cached word one cycle
// after the request; a miss reads four bytes from memory, assembles them
// little-endian, fills the cache and returns the word.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   rdy             global ready; low freezes all state
//   fetch_req_i     IF requests the instruction at pc_i
//   pc_i            word-aligned fetch address
//   flush_i         redirect; abort the current fetch
//   icache_rpc_o    cache lookup address (combinational copy of pc_i)
//   icache_hit_i    cache hit for icache_rpc_o
//   icache_inst_i   cached word
//   icache_we_o     cache fill strobe
//   icache_wpc_o    fill address
//   icache_winst_o  fill data
//   mem_req_o       byte read request
//   mem_addr_o      byte address requested
//   mem_ack_i       byte returned this cycle
//   mem_data_i      returned byte
//   inst_valid_o    one-cycle pulse: inst_o / inst_pc_o valid
//   inst_o          fetched instruction
//   inst_pc_o       PC of inst_o
//   busy_o          fetch unit is not IDLE
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = AddrBus,
    parameter int INST_WIDTH = InstBus
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  fetch_req_i,
    input  logic [ADDR_WIDTH-1:0] pc_i,
    input  logic                  flush_i,
    output logic [ADDR_WIDTH-1:0] icache_rpc_o,
    input  logic                  icache_hit_i,
    input  logic [INST_WIDTH-1:0] icache_inst_i,
    output logic                  icache_we_o,
    output logic [ADDR_WIDTH-1:0] icache_wpc_o,
    output logic [INST_WIDTH-1:0] icache_winst_o,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_ack_i,
    input  logic [ByteBus-1:0]    mem_data_i,
    output logic                  inst_valid_o,
    output logic [INST_WIDTH-1:0] inst_o,
    output logic [ADDR_WIDTH-1:0] inst_pc_o,
    output logic                  busy_o
);

    localparam int INST_BYTES = INST_WIDTH / ByteBus;

    fetch_state_e state_q, state_d;

    logic [ADDR_WIDTH-1:0] fetchPc_q, fetchPc_d;
    logic                  memReq_q, memReq_d;
    logic [ADDR_WIDTH-1:0] memAddr_q, memAddr_d;
    logic                  instValid_q, instValid_d;
    logic [INST_WIDTH-1:0] inst_q, inst_d;
    logic [ADDR_WIDTH-1:0] instPc_q, instPc_d;
    logic                  icacheWe_q, icacheWe_d;
    logic [ADDR_WIDTH-1:0] icacheWpc_q, icacheWpc_d;
    logic [INST_WIDTH-1:0] icacheWinst_q, icacheWinst_d;

    logic                          bufClear;
    logic                          bufLoad;
    logic [$clog2(INST_BYTES)-1:0] bufIdx;
    logic [INST_WIDTH-1:0]         bufWord;

    fetch_byte_assembler #(
        .NUM_BYTES (INST_BYTES)
    ) u_assembler (
        .clk     (clk),
        .rst     (rst),
        .clear_i (bufClear),
        .load_i  (bufLoad),
        .idx_i   (bufIdx),
        .byte_i  (mem_data_i),
        .word_o  (bufWord)
    );

    // State and output registers. Reset has priority over rdy; while rdy is
    // low every register simply holds, including a pending valid pulse.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q       <= IDLE;
            fetchPc_q     <= '0;
            memReq_q      <= False_v;
            memAddr_q     <= '0;
            instValid_q   <= False_v;
            inst_q        <= '0;
            instPc_q      <= '0;
            icacheWe_q    <= False_v;
            icacheWpc_q   <= '0;
            icacheWinst_q <= '0;
        end else if (rdy) begin
            state_q       <= state_d;
            fetchPc_q     <= fetchPc_d;
            memReq_q      <= memReq_d;
            memAddr_q     <= memAddr_d;
            instValid_q   <= instValid_d;
            inst_q        <= inst_d;
            instPc_q      <= instPc_d;
            icacheWe_q    <= icacheWe_d;
            icacheWpc_q   <= icacheWpc_d;
            icacheWinst_q <= icacheWinst_d;
        end
    end

    // Next-state and registered-output logic. Pulses (valid, cache write)
    // default low; data/address outputs default to holding. The memory
    // request and address are set up one state ahead so they are valid in
    // the cycle each byte state is entered. Buffer control is only issued
    // when rdy is high, since the assembler has no stall input.
    always_comb begin
        state_d       = state_q;
        fetchPc_d     = fetchPc_q;
        memReq_d      = memReq_q;
        memAddr_d     = memAddr_q;
        instValid_d   = False_v;
        inst_d        = inst_q;
        instPc_d      = instPc_q;
        icacheWe_d    = False_v;
        icacheWpc_d   = icacheWpc_q;
        icacheWinst_d = icacheWinst_q;
        bufClear      = False_v;
        bufLoad       = False_v;
        bufIdx        = byteIndex(state_q);

        if (rdy) begin
            case (state_q)
                IDLE: begin
                    if (fetch_req_i && !flush_i) begin
                        if (icache_hit_i) begin
                            instValid_d = True_v;
                            inst_d      = icache_inst_i;
                            instPc_d    = pc_i;
                        end else begin
                            fetchPc_d = pc_i;
                            memReq_d  = True_v;
                            memAddr_d = pc_i;
                            bufClear  = True_v;
                            state_d   = B0;
                        end
                    end
                end

                B0, B1, B2, B3: begin
                    // A flush beats a same-cycle ack: the byte is dropped
                    // together with everything collected so far.
                    if (flush_i) begin
                        memReq_d = False_v;
                        bufClear = True_v;
                        state_d  = IDLE;
                    end else if (mem_ack_i) begin
                        bufLoad = True_v;
                        if (state_q == B3) begin
                            memReq_d = False_v;
                            state_d  = FILL;
                        end else begin
                            memAddr_d = fetchPc_q + ADDR_WIDTH'(bufIdx) + ADDR_WIDTH'(1);
                            case (state_q)
                                B0:      state_d = B1;
                                B1:      state_d = B2;
                                default: state_d = B3;
                            endcase
                        end
                    end
                end

                FILL: begin
                    // The word is already correct for fetchPc, so the cache
                    // is filled even on a flush; only the hand-off to IF is
                    // cancelled.
                    icacheWe_d    = True_v;
                    icacheWpc_d   = fetchPc_q;
                    icacheWinst_d = bufWord;
                    if (!flush_i) begin
                        instValid_d = True_v;
                        inst_d      = bufWord;
                        instPc_d    = fetchPc_q;
                    end
                    state_d = IDLE;
                end

                default: begin
                    memReq_d = False_v;
                    state_d  = IDLE;
                end
            endcase
        end
    end

    assign icache_rpc_o   = pc_i;
    assign icache_we_o    = icacheWe_q;
    assign icache_wpc_o   = icacheWpc_q;
    assign icache_winst_o = icacheWinst_q;
    assign mem_req_o      = memReq_q & rdy;
    assign mem_addr_o     = memAddr_q;
    assign inst_valid_o   = instValid_q;
    assign inst_o         = inst_q;
    assign inst_pc_o      = instPc_q;
    assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit
// Directed bench for inst_fetch_unit with a small direct-mapped cache model
// and a byte memory responder with configurable ack latency.
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        fetch_req_i;
    logic [31:0] pc_i;
    logic        flush_i;
    logic [31:0] icache_rpc_o;
    logic        icache_hit_i;
    logic [31:0] icache_inst_i;
    logic        icache_we_o;
    logic [31:0] icache_wpc_o;
    logic [31:0] icache_winst_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [7:0]  mem_data_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        busy_o;

    int vectorCount = 0;
    int missCount   = 0;

    // Cache model state
    logic [31:0] cacheTag   [8];
    logic [31:0] cacheData  [8];
    logic        cacheValid [8];

    // Memory responder state
    int          memLatency  = 1;
    logic        autoMem     = 1'b1;
    logic        memAckAuto  = 1'b0;
    logic [7:0]  memDataAuto = 8'h00;
    logic        memAckManual  = 1'b0;
    logic [7:0]  memDataManual = 8'h00;
    logic        pending = 1'b0;
    logic [31:0] pendAddr = 32'h0;
    int          waitCnt = 0;
    logic [31:0] ackAddr [256];
    int          ackCount = 0;

    inst_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .fetch_req_i    (fetch_req_i),
        .pc_i           (pc_i),
        .flush_i        (flush_i),
        .icache_rpc_o   (icache_rpc_o),
        .icache_hit_i   (icache_hit_i),
        .icache_inst_i  (icache_inst_i),
        .icache_we_o    (icache_we_o),
        .icache_wpc_o   (icache_wpc_o),
        .icache_winst_o (icache_winst_o),
        .mem_req_o      (mem_req_o),
        .mem_addr_o     (mem_addr_o),
        .mem_ack_i      (mem_ack_i),
        .mem_data_i     (mem_data_i),
        .inst_valid_o   (inst_valid_o),
        .inst_o         (inst_o),
        .inst_pc_o      (inst_pc_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    // Memory contents: the instruction at 0x2004 is fixed, everything else
    // follows a simple address formula.
    function automatic logic [7:0] memByteOf(input logic [31:0] a);
        case (a)
            32'h2004: return 8'h13;
            32'h2005: return 8'h05;
            32'h2006: return 8'h10;
            32'h2007: return 8'h00;
            default:  return a[7:0] ^ a[15:8] ^ 8'h5A;
        endcase
    endfunction

    // Direct-mapped cache model, index pc[4:2]; reset preloads 0x1000
    assign icache_hit_i  = cacheValid[icache_rpc_o[4:2]] && (cacheTag[icache_rpc_o[4:2]] == icache_rpc_o);
    assign icache_inst_i = cacheData[icache_rpc_o[4:2]];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                cacheValid[i] <= 1'b0;
                cacheTag[i]   <= 32'h0;
                cacheData[i]  <= 32'h0;
            end
            cacheValid[0] <= 1'b1;
            cacheTag[0]   <= 32'h0000_1000;
            cacheData[0]  <= 32'h00A0_0093;
        end else if (icache_we_o) begin
            cacheValid[icache_wpc_o[4:2]] <= 1'b1;
            cacheTag[icache_wpc_o[4:2]]   <= icache_wpc_o;
            cacheData[icache_wpc_o[4:2]]  <= icache_winst_o;
        end
    end

    // Memory responder: acks on the memLatency-th cycle a given address has
    // been requested, and logs every acknowledged address in order.
    always @(negedge clk) begin
        memAckAuto = 1'b0;
        if (mem_req_o) begin
            if (!pending || mem_addr_o != pendAddr) begin
                pending  = 1'b1;
                pendAddr = mem_addr_o;
                waitCnt  = 0;
            end
            waitCnt++;
            if (waitCnt >= memLatency) begin
                memAckAuto  = 1'b1;
                memDataAuto = memByteOf(mem_addr_o);
                if (ackCount < 256) ackAddr[ackCount] = mem_addr_o;
                ackCount++;
                pending = 1'b0;
            end
        end else begin
            pending = 1'b0;
        end
    end

    assign mem_ack_i  = autoMem ? memAckAuto  : memAckManual;
    assign mem_data_i = autoMem ? memDataAuto : memDataManual;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic req, input logic [31:0] pc, input logic flush);
        fetch_req_i = req;
        pc_i        = pc;
        flush_i     = flush;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Step until the fill/return cycle shows up; a blown budget counts as a failure
    task automatic waitFill(input string tag, output int cycles);
        cycles = 0;
        while (!(inst_valid_o || icache_we_o) && cycles < 200) begin
            stepCycle();
            cycles++;
        end
        if (!(inst_valid_o || icache_we_o)) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Step until the given byte address is being requested
    task automatic waitAddr(input string tag, input logic [31:0] a);
        int n = 0;
        while (!(busy_o && mem_req_o && mem_addr_o == a) && n < 200) begin
            stepCycle();
            n++;
        end
        if (!(busy_o && mem_req_o && mem_addr_o == a)) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        int cyc;
        int base;
        int n;

        rst = 1'b1;
        rdy = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0);
        repeat (3) stepCycle();

        // Reset state
        checkOutput("rst_valid",  {31'd0, inst_valid_o}, 32'd0);
        checkOutput("rst_busy",   {31'd0, busy_o},       32'd0);
        checkOutput("rst_memreq", {31'd0, mem_req_o},    32'd0);
        checkOutput("rst_we",     {31'd0, icache_we_o},  32'd0);
        checkOutput("rst_inst",   inst_o,                32'd0);
        rst = 1'b0;
        stepCycle();

        // Hit at 0x1000
        applyStimulus(1'b1, 32'h1000, 1'b0);
        checkOutput("hit_rpc", icache_rpc_o, 32'h1000);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("hit_valid",  {31'd0, inst_valid_o}, 32'd1);
        checkOutput("hit_inst",   inst_o,                32'h00A0_0093);
        checkOutput("hit_pc",     inst_pc_o,             32'h1000);
        checkOutput("hit_memreq", {31'd0, mem_req_o},    32'd0);
        checkOutput("hit_busy",   {31'd0, busy_o},       32'd0);
        stepCycle();
        checkOutput("hit_pulse",  {31'd0, inst_valid_o}, 32'd0);

        // Flush in IDLE suppresses a hit
        applyStimulus(1'b1, 32'h1000, 1'b1);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("idleflush_valid", {31'd0, inst_valid_o}, 32'd0);
        checkOutput("idleflush_busy",  {31'd0, busy_o},       32'd0);

        // Miss at 0x2004, ack latency 3
        memLatency = 3;
        base = ackCount;
        applyStimulus(1'b1, 32'h2004, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("miss_busy",   {31'd0, busy_o},    32'd1);
        checkOutput("miss_memreq", {31'd0, mem_req_o}, 32'd1);
        checkOutput("miss_addr0",  mem_addr_o,         32'h2004);
        waitFill("miss", cyc);
        checkOutput("miss_latency", cyc,                   32'd13);
        checkOutput("miss_valid",   {31'd0, inst_valid_o}, 32'd1);
        checkOutput("miss_inst",    inst_o,                32'h0010_0513);
        checkOutput("miss_pc",      inst_pc_o,             32'h2004);
        checkOutput("miss_we",      {31'd0, icache_we_o},  32'd1);
        checkOutput("miss_winst",   icache_winst_o,        32'h0010_0513);
        checkOutput("miss_wpc",     icache_wpc_o,          32'h2004);
        checkOutput("miss_acks",    ackCount - base,       32'd4);
        for (int k = 0; k < 4; k++) checkOutput($sformatf("miss_ackaddr%0d", k), ackAddr[base + k], 32'h2004 + k);
        stepCycle();
        checkOutput("miss_wepulse", {31'd0, icache_we_o}, 32'd0);

        // Re-fetch of 0x2004 now hits
        applyStimulus(1'b1, 32'h2004, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("refetch_valid",  {31'd0, inst_valid_o}, 32'd1);
        checkOutput("refetch_inst",   inst_o,                32'h0010_0513);
        checkOutput("refetch_memreq", {31'd0, mem_req_o},    32'd0);

        // Flush during B2
        memLatency = 2;
        applyStimulus(1'b1, 32'h3000, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 1'b0);
        waitAddr("flushb2", 32'h3002);
        flush_i = 1'b1;
        stepCycle();
        flush_i = 1'b0;
        checkOutput("flushb2_memreq", {31'd0, mem_req_o},    32'd0);
        checkOutput("flushb2_busy",   {31'd0, busy_o},       32'd0);
        checkOutput("flushb2_we",     {31'd0, icache_we_o},  32'd0);
        checkOutput("flushb2_valid",  {31'd0, inst_valid_o}, 32'd0);
        stepCycle();
        checkOutput("flushb2_we2",    {31'd0, icache_we_o},  32'd0);
        checkOutput("flushb2_valid2", {31'd0, inst_valid_o}, 32'd0);
        applyStimulus(1'b1, 32'h3000, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("flushb2_remiss", {31'd0, mem_req_o}, 32'd1);
        checkOutput("flushb2_readdr", mem_addr_o,         32'h3000);
        waitFill("flushb2_refill", cyc);
        checkOutput("flushb2_inst",   inst_o,             32'h6968_6B6A);
        stepCycle();

        // Flush coincident with the B3 ack
        base = ackCount;
        applyStimulus(1'b1, 32'h4000, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 1'b0);
        waitAddr("flushb3", 32'h4003);
        stepCycle();
        flush_i = 1'b1;
        stepCycle();
        flush_i = 1'b0;
        checkOutput("flushb3_ackseen", ackCount - base,       32'd4);
        checkOutput("flushb3_busy",    {31'd0, busy_o},       32'd0);
        checkOutput("flushb3_we",      {31'd0, icache_we_o},  32'd0);
        checkOutput("flushb3_valid",   {31'd0, inst_valid_o}, 32'd0);
        stepCycle();
        checkOutput("flushb3_we2",     {31'd0, icache_we_o},  32'd0);
        checkOutput("flushb3_valid2",  {31'd0, inst_valid_o}, 32'd0);

        // Flush in FILL: cache still written, no valid
        memLatency = 1;
        applyStimulus(1'b1, 32'h5000, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 1'b0);
        n = 0;
        while (!(busy_o && !mem_req_o) && n < 100) begin
            stepCycle();
            n++;
        end
        checkOutput("flushfill_reached", {31'd0, busy_o && !mem_req_o}, 32'd1);
        flush_i = 1'b1;
        stepCycle();
        flush_i = 1'b0;
        checkOutput("flushfill_we",    {31'd0, icache_we_o},  32'd1);
        checkOutput("flushfill_wpc",   icache_wpc_o,          32'h5000);
        checkOutput("flushfill_winst", icache_winst_o,        32'h0908_0B0A);
        checkOutput("flushfill_valid", {31'd0, inst_valid_o}, 32'd0);
        checkOutput("flushfill_busy",  {31'd0, busy_o},       32'd0);
        stepCycle();

        // rdy stall during B1 with stray acks
        memLatency = 2;
        applyStimulus(1'b1, 32'h6000, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 1'b0);
        waitAddr("stall", 32'h6001);
        autoMem = 1'b0;
        rdy     = 1'b0;
        memDataManual = 8'hEE;
        for (int c = 0; c < 5; c++) begin
            memAckManual = c[0];
            stepCycle();
            checkOutput($sformatf("stall_memreq%0d", c), {31'd0, mem_req_o}, 32'd0);
            checkOutput($sformatf("stall_busy%0d", c),   {31'd0, busy_o},    32'd1);
        end
        checkOutput("stall_addr", mem_addr_o, 32'h6001);
        memAckManual = 1'b0;
        autoMem = 1'b1;
        rdy     = 1'b1;
        #1;
        checkOutput("stall_resume_req", {31'd0, mem_req_o}, 32'd1);
        waitFill("stall", cyc);
        checkOutput("stall_inst",  inst_o,                32'h3938_3B3A);
        checkOutput("stall_pc",    inst_pc_o,             32'h6000);
        checkOutput("stall_valid", {31'd0, inst_valid_o}, 32'd1);
        stepCycle();

        // Reset during B3
        memLatency = 3;
        applyStimulus(1'b1, 32'h7000, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 1'b0);
        waitAddr("rstfill", 32'h7003);
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
        checkOutput("rstfill_valid",  {31'd0, inst_valid_o}, 32'd0);
        checkOutput("rstfill_we",     {31'd0, icache_we_o},  32'd0);
        checkOutput("rstfill_memreq", {31'd0, mem_req_o},    32'd0);
        checkOutput("rstfill_busy",   {31'd0, busy_o},       32'd0);
        checkOutput("rstfill_inst",   inst_o,                32'd0);
        checkOutput("rstfill_instpc", inst_pc_o,             32'd0);
        checkOutput("rstfill_winst",  icache_winst_o,        32'd0);
        checkOutput("rstfill_wpc",    icache_wpc_o,          32'd0);
        checkOutput("rstfill_addr",   mem_addr_o,            32'd0);
        stepCycle();
        checkOutput("rstfill_we2",    {31'd0, icache_we_o},  32'd0);

        // Address wrap at the top of memory
        memLatency = 1;
        base = ackCount;
        applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 1'b0);
        waitFill("wrap", cyc);
        checkOutput("wrap_inst", inst_o,          32'h5A5B_5859);
        checkOutput("wrap_pc",   inst_pc_o,       32'hFFFF_FFFC);
        checkOutput("wrap_acks", ackCount - base, 32'd4);
        for (int k = 0; k < 4; k++) checkOutput($sformatf("wrap_ackaddr%0d", k), ackAddr[base + k], 32'hFFFF_FFFC + k);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
